// File: rtl/rr_arbiter_16.sv
// ---------------------------------------------------------------------------
// rr_arbiter_16 -- 16-way round-robin arbiter with a per-winner hold limit.
//
// A request vector is arbitrated in IDLE: the first set bit found scanning
// from the priority pointer upward (wrapping at 15) wins. The winner holds
// the grant in GRANT until it drops its request or has held for MAX_HOLD
// cycles. A timeout-driven release pulses `timeout` for one cycle. Every
// release passes through IDLE, which leaves one dead cycle between grants.
//
// Parameters
//   MAX_HOLD   maximum consecutive grant cycles per winner; 0 = unlimited
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request vector; bit i belongs to requester i
//   gnt        registered one-hot grant, all-zero when no grant is held
//   gnt_id     binary index of the granted requester (0 when idle)
//   gnt_valid  high while a grant is held
//   timeout    one-cycle pulse following a forced release
// ---------------------------------------------------------------------------
module rr_arbiter_16 #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_id,
   output logic        gnt_valid,
   output logic        timeout
);

   // The counter must be able to hold the value MAX_HOLD itself.
   localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam bit HOLD_LIMITED = (MAX_HOLD != 0);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state;
   logic [3:0]        ptr;
   logic [HOLD_W-1:0] hold_cnt;

   logic              win_found;
   logic [3:0]        win_id;
   logic              release_now;
   logic              hold_expired;

   // Rotating priority search. The index sum is 4 bits wide, so it wraps
   // from 15 back to 0 on its own and the scan covers ptr..15, 0..ptr-1.
   always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // path through the loop leaves it unassigned and infers a latch.
      win_found = 1'b0;
      win_id    = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (!win_found && req[ptr + 4'(i)]) begin
            win_found = 1'b1;
            win_id    = ptr + 4'(i);
         end
      end
   end

   // Release when the holder lets go, or when a bounded hold reaches its limit.
   assign hold_expired = HOLD_LIMITED && (hold_cnt == HOLD_LIMIT);
   assign release_now  = !req[gnt_id] || hold_expired;

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 4'd0;
         hold_cnt  <= '0;
         gnt       <= 16'd0;
         gnt_id    <= 4'd0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         // timeout is a pulse: it only survives the cycle after a forced release.
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state     <= GRANT;
                  gnt_id    <= win_id;
                  gnt       <= 16'd1 << win_id;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= HOLD_W'(1);
                  ptr       <= win_id + 4'd1;   // winner 15 wraps to 0
               end
            end
            GRANT: begin
               if (release_now) begin
                  state     <= IDLE;
                  gnt       <= 16'd0;
                  gnt_id    <= 4'd0;
                  gnt_valid <= 1'b0;
                  hold_cnt  <= '0;
                  // Still requesting at release means the limit forced it out.
                  timeout   <= req[gnt_id];
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/rr_arbiter_16.md
RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 8, max consecutive grant cycles per winner; 0 = unlimited.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req  input  16  request vector, bit i = requester i.
REQ-005 SHALL have port: gnt  output  16  registered one-hot grant, all-zero when none.
REQ-006 SHALL have port: gnt_id  output  4  binary index of granted requester; gnt SHALL equal the 4-to-16 one-hot decode of gnt_id while gnt_valid=1.
REQ-007 SHALL have port: gnt_valid  output  1  high while a grant is held.
REQ-008 SHALL have port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-009 SHALL implement a two-state FSM, IDLE and GRANT, plus a 4-bit priority pointer ptr and a hold counter wide enough for MAX_HOLD.
REQ-010 IDLE: on a rising edge with req!=0, SHALL select the first set bit scanning ptr, ptr+1, ... 15, 0, ... ptr-1. The same edge SHALL load gnt_id=winner, gnt=decode(winner), gnt_valid=1, hold counter=1, ptr=winner+1 mod 16, and move to GRANT.
REQ-011 Latency SHALL be exactly one edge: req sampled at edge N -> gnt visible after edge N.
REQ-012 IDLE with req=0: SHALL hold all outputs at 0, with ptr unchanged.
REQ-013 GRANT: while req[gnt_id]=1 and the hold limit is not reached, each edge SHALL increment the hold counter and keep gnt, gnt_id, gnt_valid unchanged.
REQ-014 Voluntary release: at an edge in GRANT with req[gnt_id]=0, SHALL clear gnt, gnt_valid, gnt_id to 0 and return to IDLE, with timeout=0.
REQ-015 Forced release: with MAX_HOLD!=0, at the edge where the hold counter equals MAX_HOLD and req[gnt_id]=1, SHALL clear the grant, return to IDLE, and assert timeout for exactly that following cycle.
REQ-016 Each release SHALL be followed by at least one IDLE cycle (gnt=0), so back-to-back grants are separated by one dead cycle.
REQ-017 Requests from other bits during GRANT SHALL be ignored (no preemption); they are arbitrated on the next IDLE edge.
REQ-018 Pointer wrap: winner 15 SHALL set ptr=0.
REQ-019 A requester released by timeout SHALL have lowest priority at the next arbitration (ptr already past it); it SHALL be re-granted only if no other req bit is set.
REQ-020 gnt SHALL never have more than one bit set in any cycle.
REQ-021 MAX_HOLD=0: a grant SHALL persist until voluntary release, and timeout SHALL never assert.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock edge, force state=IDLE, ptr=0, hold counter=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
REQ-023 Reset asserted mid-GRANT SHALL drop the grant asynchronously. After deassertion, the first arbitration SHALL start from ptr=0.
REQ-024 Outputs SHALL remain at reset values while rst_n=0 regardless of req.

Verification
REQ-025 After reset, req=16'h0001 held -> after next edge gnt=16'h0001, gnt_id=0, gnt_valid=1. Drop req -> next edge gnt=0.
REQ-026 req=16'hFFFF, each winner drops its bit 2 cycles after grant and re-raises it after release -> gnt_id sequence 0,1,2,...,15,0,1, one dead cycle between grants.
REQ-027 MAX_HOLD=8, only req[5] held high -> gnt=16'h0020 for 8 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=16'h0020 again.
REQ-028 MAX_HOLD=8, req[5] and req[9] held high -> 5 granted for 8 cycles, timeout, then 9 granted 8 cycles, then 5: strict alternation.
REQ-029 Grant to bit 14 released, then req = bits 15 and 3 -> gnt_id=15 first, then ptr=0, then gnt_id=3.
REQ-030 Assert rst_n=0 between clock edges during a grant to bit 7 -> gnt=0, gnt_valid=0 before the next edge. After release with req=16'h0081 -> gnt_id=0 first.
